pipe_de_regs: RTL and testbench

PIPE_DE_REGS -- requirements
Module: pipe_de_regs

---
 rtl/pipe_pkg.sv | 30 +++
 rtl/pipe_de_regs_if.sv | 36 +++
 rtl/pipe_reg.sv | 20 ++
 rtl/pipe_de_regs.sv | 84 ++++++++
 tb/tb_pipe_de_regs.sv | 140 ++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared widths, forward-select encodings and register bundles for the
// IF/ID and ID/EX pipeline registers.
package pipe_pkg;
  localparam int XLEN   = 32;
  localparam int REG_W  = 5;
  localparam int CTRL_W = 8;
  localparam int CNT_W  = 16;

  typedef logic [1:0] fwd_t;
  localparam fwd_t FWD_RF = 2'b00;
  localparam fwd_t FWD_W  = 2'b01;
  localparam fwd_t FWD_M  = 2'b10;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pcplus4;
    logic            valid;
  } ifid_t;

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt;
    logic [REG_W-1:0]  rd;
    logic [XLEN-1:0]   rd1;
    logic [XLEN-1:0]   rd2;
    logic [XLEN-1:0]   imm;
    logic              valid;
  } idex_t;
endpackage

// File: rtl/pipe_de_regs_if.sv
// Hazard controls, decode-side data and registered/forwarded results of the
// decode/execute pipeline register block.
interface pipe_de_regs_if;
  import pipe_pkg::*;

  logic                   Stall, Flush, PCSrcD, ClrCnt;
  logic                   ForwardAD, ForwardBD;
  fwd_t                   ForwardAE, ForwardBE;
  logic [XLEN-1:0]        InstrF, PCPlus4F;
  logic [XLEN-1:0]        InstrD, PCPlus4D;
  logic                   ValidD, ValidE;
  logic [XLEN-1:0]        RD1D, RD2D, SignImmD;
  logic [CTRL_W-1:0]      CtrlD;
  logic [REG_W-1:0]       rsD, rtD, rdD;
  logic [XLEN-1:0]        ALUOutM, ResultW;
  logic                   EqualD;
  logic [CTRL_W-1:0]      CtrlE;
  logic [REG_W-1:0]       rsE, rtE, rdE;
  logic [XLEN-1:0]        RD1E, RD2E, SignImmE;
  logic [XLEN-1:0]        SrcAE, WriteDataE;
  logic [CNT_W-1:0]       StallCnt, FlushCnt;

  modport master (
    output Stall, Flush, PCSrcD, ClrCnt, ForwardAD, ForwardBD, ForwardAE, ForwardBE,
           InstrF, PCPlus4F, RD1D, RD2D, SignImmD, CtrlD, rsD, rtD, rdD, ALUOutM, ResultW,
    input  InstrD, PCPlus4D, ValidD, ValidE, EqualD, CtrlE, rsE, rtE, rdE,
           RD1E, RD2E, SignImmE, SrcAE, WriteDataE, StallCnt, FlushCnt
  );

  modport slave (
    input  Stall, Flush, PCSrcD, ClrCnt, ForwardAD, ForwardBD, ForwardAE, ForwardBE,
           InstrF, PCPlus4F, RD1D, RD2D, SignImmD, CtrlD, rsD, rtD, rdD, ALUOutM, ResultW,
    output InstrD, PCPlus4D, ValidD, ValidE, EqualD, CtrlE, rsE, rtE, rdE,
           RD1E, RD2E, SignImmE, SrcAE, WriteDataE, StallCnt, FlushCnt
  );
endinterface

// File: rtl/pipe_reg.sv
// Generic pipeline register: clear beats enable; async reset to zero.
module pipe_reg #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      q <= '0;
    else if (clr)
      q <= '0;
    else if (en)
      q <= d;
  end
endmodule

// File: rtl/pipe_de_regs.sv
// IF/ID and ID/EX pipeline registers with decode/execute forwarding muxes
// and saturating stall/flush event counters.
module pipe_de_regs
  import pipe_pkg::*;
(
  input logic          clk,
  input logic          rst,
  pipe_de_regs_if.slave bus
);
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  function automatic logic [XLEN-1:0] fwd_mux(input fwd_t sel, input logic [XLEN-1:0] rf,
                                              input logic [XLEN-1:0] w, input logic [XLEN-1:0] m);
    case (sel)
      FWD_W:   return w;
      FWD_M:   return m;
      default: return rf;
    endcase
  endfunction

  ifid_t ifid_p0_d, ifid_p0;
  idex_t idex_p1_d, idex_p1;
  logic  ifid_en, ifid_clr, flush_evt;
  logic [XLEN-1:0] cmp_a, cmp_b;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  // IF/ID stage: a stall freezes the register, so a branch squash only lands when not stalled
  assign ifid_en   = ~bus.Stall;
  assign ifid_clr  = bus.PCSrcD & ~bus.Stall;
  assign ifid_p0_d = '{instr: bus.InstrF, pcplus4: bus.PCPlus4F, valid: 1'b1};

  pipe_reg #(.DATA_W($bits(ifid_t))) u_ifid (
    .clk(clk), .rst(rst), .en(ifid_en), .clr(ifid_clr), .d(ifid_p0_d), .q(ifid_p0)
  );

  assign bus.InstrD   = ifid_p0.instr;
  assign bus.PCPlus4D = ifid_p0.pcplus4;
  assign bus.ValidD   = ifid_p0.valid;

  assign cmp_a      = bus.ForwardAD ? bus.ALUOutM : bus.RD1D;
  assign cmp_b      = bus.ForwardBD ? bus.ALUOutM : bus.RD2D;
  assign bus.EqualD = (cmp_a == cmp_b);

  // ID/EX stage: always advances; Flush turns it into a bubble
  assign idex_p1_d = '{ctrl: bus.CtrlD, rs: bus.rsD, rt: bus.rtD, rd: bus.rdD,
                       rd1: bus.RD1D, rd2: bus.RD2D, imm: bus.SignImmD, valid: ifid_p0.valid};

  pipe_reg #(.DATA_W($bits(idex_t))) u_idex (
    .clk(clk), .rst(rst), .en(1'b1), .clr(bus.Flush), .d(idex_p1_d), .q(idex_p1)
  );

  assign bus.CtrlE    = idex_p1.ctrl;
  assign bus.rsE      = idex_p1.rs;
  assign bus.rtE      = idex_p1.rt;
  assign bus.rdE      = idex_p1.rd;
  assign bus.RD1E     = idex_p1.rd1;
  assign bus.RD2E     = idex_p1.rd2;
  assign bus.SignImmE = idex_p1.imm;
  assign bus.ValidE   = idex_p1.valid;

  assign bus.SrcAE      = fwd_mux(bus.ForwardAE, idex_p1.rd1, bus.ResultW, bus.ALUOutM);
  assign bus.WriteDataE = fwd_mux(bus.ForwardBE, idex_p1.rd2, bus.ResultW, bus.ALUOutM);

  // Event counters: a squash and a flush in the same cycle still count once
  assign flush_evt = bus.Flush | (bus.PCSrcD & ~bus.Stall);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (bus.ClrCnt) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (bus.Stall) stall_cnt <= sat_inc(stall_cnt);
      if (flush_evt) flush_cnt <= sat_inc(flush_cnt);
    end
  end

  assign bus.StallCnt = stall_cnt;
  assign bus.FlushCnt = flush_cnt;
endmodule

// File: tb/tb_pipe_de_regs.sv
// Directed bench for pipe_de_regs: loads, stalls, squashes, forwarding,
// counter saturation/clear and asynchronous reset.
module tb_pipe_de_regs;
  import pipe_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  pipe_de_regs_if bus ();

  pipe_de_regs dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.Stall = 0; bus.Flush = 0; bus.PCSrcD = 0; bus.ClrCnt = 0;
    bus.ForwardAD = 0; bus.ForwardBD = 0; bus.ForwardAE = FWD_RF; bus.ForwardBE = FWD_RF;
    bus.InstrF = '0; bus.PCPlus4F = '0; bus.RD1D = '0; bus.RD2D = '0; bus.SignImmD = '0;
    bus.CtrlD = '0; bus.rsD = '0; bus.rtD = '0; bus.rdD = '0; bus.ALUOutM = '0; bus.ResultW = '0;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    checks++; if (bus.InstrD !== 32'h0) begin errors++; $display("FAIL reset_instrd got %h want 0", bus.InstrD); end
    checks++; if (bus.ValidD !== 1'b0 || bus.ValidE !== 1'b0) begin errors++; $display("FAIL reset_valid got %b%b want 00", bus.ValidD, bus.ValidE); end
    checks++; if (bus.CtrlE !== 8'h0 || bus.RD1E !== 32'h0) begin errors++; $display("FAIL reset_idex got %h/%h want 0/0", bus.CtrlE, bus.RD1E); end
    checks++; if (bus.StallCnt !== 16'h0 || bus.FlushCnt !== 16'h0) begin errors++; $display("FAIL reset_cnt got %h/%h want 0/0", bus.StallCnt, bus.FlushCnt); end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_load();
    bus.InstrF = 32'h8C220004; bus.PCPlus4F = 32'h0000_0104; bus.CtrlD = 8'h03;
    bus.rsD = 5'd1; bus.rtD = 5'd2; bus.rdD = 5'd3; bus.SignImmD = 32'h4;
    tick();
    checks++; if (bus.InstrD !== 32'h8C220004 || bus.ValidD !== 1'b1) begin errors++; $display("FAIL load_ifid got %h/%b want 8c220004/1", bus.InstrD, bus.ValidD); end
    checks++; if (bus.PCPlus4D !== 32'h104 || bus.ValidE !== 1'b0) begin errors++; $display("FAIL load_pc got %h/%b want 104/0", bus.PCPlus4D, bus.ValidE); end
    tick();
    checks++; if (bus.ValidE !== 1'b1 || bus.CtrlE !== 8'h03) begin errors++; $display("FAIL load_idex got %b/%h want 1/03", bus.ValidE, bus.CtrlE); end
    checks++; if (bus.rtE !== 5'd2 || bus.SignImmE !== 32'h4) begin errors++; $display("FAIL load_regs got %h/%h want 02/4", bus.rtE, bus.SignImmE); end
  endtask

  task automatic test_stall_flush();
    bus.ClrCnt = 1; tick(); bus.ClrCnt = 0;
    // InstrD now 8C220004; stall+flush twice with a changing fetch stream
    bus.Stall = 1; bus.Flush = 1;
    bus.InstrF = 32'h11111111; tick();
    checks++; if (bus.CtrlE !== 8'h0 || bus.ValidE !== 1'b0) begin errors++; $display("FAIL stall_bubble1 got %h/%b want 00/0", bus.CtrlE, bus.ValidE); end
    bus.InstrF = 32'h22222222; tick();
    checks++; if (bus.InstrD !== 32'h8C220004) begin errors++; $display("FAIL stall_hold got %h want 8c220004", bus.InstrD); end
    checks++; if (bus.CtrlE !== 8'h0 || bus.ValidE !== 1'b0) begin errors++; $display("FAIL stall_bubble2 got %h/%b want 00/0", bus.CtrlE, bus.ValidE); end
    checks++; if (bus.StallCnt !== 16'd2 || bus.FlushCnt !== 16'd2) begin errors++; $display("FAIL stall_cnt got %0d/%0d want 2/2", bus.StallCnt, bus.FlushCnt); end
    // stall without flush still advances ID/EX
    bus.Flush = 0; bus.CtrlD = 8'hA5; tick();
    checks++; if (bus.CtrlE !== 8'hA5 || bus.ValidE !== 1'b1) begin errors++; $display("FAIL stall_noflush got %h/%b want a5/1", bus.CtrlE, bus.ValidE); end
    checks++; if (bus.StallCnt !== 16'd3 || bus.FlushCnt !== 16'd2) begin errors++; $display("FAIL stall_cnt3 got %0d/%0d want 3/2", bus.StallCnt, bus.FlushCnt); end
    bus.Stall = 0; bus.ClrCnt = 1; tick(); bus.ClrCnt = 0;
    checks++; if (bus.InstrD !== 32'h22222222 || bus.StallCnt !== 16'd0) begin errors++; $display("FAIL stall_release got %h/%0d want 22222222/0", bus.InstrD, bus.StallCnt); end
  endtask

  task automatic test_branch();
    bus.PCSrcD = 1; tick();
    checks++; if (bus.InstrD !== 32'h0 || bus.ValidD !== 1'b0 || bus.PCPlus4D !== 32'h0) begin errors++; $display("FAIL squash got %h/%b want 0/0", bus.InstrD, bus.ValidD); end
    checks++; if (bus.FlushCnt !== 16'd1) begin errors++; $display("FAIL squash_cnt got %0d want 1", bus.FlushCnt); end
    bus.PCSrcD = 0; bus.InstrF = 32'h33333333; tick();
    bus.PCSrcD = 1; bus.Stall = 1; bus.InstrF = 32'h44444444; tick();
    checks++; if (bus.InstrD !== 32'h33333333 || bus.ValidD !== 1'b1) begin errors++; $display("FAIL squash_stall got %h/%b want 33333333/1", bus.InstrD, bus.ValidD); end
    checks++; if (bus.FlushCnt !== 16'd1 || bus.StallCnt !== 16'd1) begin errors++; $display("FAIL squash_stall_cnt got %0d/%0d want 1/1", bus.FlushCnt, bus.StallCnt); end
    // squash and flush together count once
    bus.Stall = 0; bus.Flush = 1; tick();
    checks++; if (bus.FlushCnt !== 16'd2) begin errors++; $display("FAIL squash_flush_cnt got %0d want 2", bus.FlushCnt); end
    bus.PCSrcD = 0; bus.Flush = 0;
  endtask

  task automatic test_forward();
    logic [31:0] exp_a [4] = '{32'd5, 32'd9, 32'd7, 32'd5};
    logic [31:0] exp_b [4] = '{32'd6, 32'd9, 32'd7, 32'd6};
    bus.RD1D = 32'd5; bus.RD2D = 32'd6; tick();
    bus.ALUOutM = 32'd7; bus.ResultW = 32'd9;
    for (int i = 0; i < 4; i++) begin
      bus.ForwardAE = fwd_t'(i); bus.ForwardBE = fwd_t'(i); #1;
      checks++; if (bus.SrcAE !== exp_a[i]) begin errors++; $display("FAIL fwd_a%0d got %0d want %0d", i, bus.SrcAE, exp_a[i]); end
      checks++; if (bus.WriteDataE !== exp_b[i]) begin errors++; $display("FAIL fwd_b%0d got %0d want %0d", i, bus.WriteDataE, exp_b[i]); end
    end
    bus.RD1D = 32'd3; bus.RD2D = 32'd4; bus.ALUOutM = 32'd4;
    bus.ForwardAD = 0; bus.ForwardBD = 1; #1;
    checks++; if (bus.EqualD !== 1'b0) begin errors++; $display("FAIL equal_ne got %b want 0", bus.EqualD); end
    bus.ForwardAD = 1; #1;
    checks++; if (bus.EqualD !== 1'b1) begin errors++; $display("FAIL equal_eq got %b want 1", bus.EqualD); end
    bus.ForwardAD = 0; bus.ForwardBD = 0; bus.RD2D = 32'd3; #1;
    checks++; if (bus.EqualD !== 1'b1) begin errors++; $display("FAIL equal_rf got %b want 1", bus.EqualD); end
    bus.ForwardAE = FWD_RF; bus.ForwardBE = FWD_RF;
  endtask

  task automatic test_saturate();
    bus.ClrCnt = 1; tick(); bus.ClrCnt = 0;
    bus.Stall = 1;
    repeat (65534) @(posedge clk);
    #1;
    checks++; if (bus.StallCnt !== 16'hFFFE || bus.FlushCnt !== 16'h0) begin errors++; $display("FAIL sat_pre got %h/%h want fffe/0", bus.StallCnt, bus.FlushCnt); end
    repeat (6) @(posedge clk);
    #1;
    checks++; if (bus.StallCnt !== 16'hFFFF) begin errors++; $display("FAIL sat got %h want ffff", bus.StallCnt); end
    bus.ClrCnt = 1; tick(); bus.ClrCnt = 0;
    checks++; if (bus.StallCnt !== 16'h0) begin errors++; $display("FAIL sat_clr got %h want 0", bus.StallCnt); end
    bus.Stall = 0;
  endtask

  task automatic test_async_reset();
    bus.InstrF = 32'h55555555; bus.CtrlD = 8'h0F; tick();
    bus.Stall = 1; bus.InstrF = 32'h66666666; tick();
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.InstrD !== 32'h0 || bus.ValidD !== 1'b0 || bus.ValidE !== 1'b0) begin errors++; $display("FAIL arst_ifid got %h/%b%b want 0/00", bus.InstrD, bus.ValidD, bus.ValidE); end
    checks++; if (bus.CtrlE !== 8'h0 || bus.StallCnt !== 16'h0 || bus.FlushCnt !== 16'h0) begin errors++; $display("FAIL arst_rest got %h/%h/%h want 0/0/0", bus.CtrlE, bus.StallCnt, bus.FlushCnt); end
    #1 rst = 1'b0; bus.Stall = 0; bus.InstrF = 32'h77777777;
    tick();
    checks++; if (bus.InstrD !== 32'h77777777 || bus.ValidD !== 1'b1) begin errors++; $display("FAIL arst_reload got %h/%b want 77777777/1", bus.InstrD, bus.ValidD); end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_load();
    test_stall_flush();
    test_branch();
    test_forward();
    test_saturate();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
